any1_ifetch_queue: RTL

//  Line-fetch queue between the I-cache read port and the instruction aligner.

---
 rtl/any1_pkg.sv | 49 ++++
 rtl/any1_ifq_ram.sv | 26 ++
 rtl/any1_ifetch_queue.sv | 105 ++++++++++
 3 files changed

// File: rtl/any1_pkg.sv
// Shared types for the any1 fetch front end: aligner input record, fetch-queue
// entry layout and fetch-queue occupancy classification.
package any1_pkg;

  localparam int unsigned IFQ_DEPTH = 4;
  localparam int unsigned LINE_W    = 512;
  localparam int unsigned IP_W      = 32;

  typedef struct packed {
    logic              v;
    logic              predict_taken;
    logic [LINE_W-1:0] cacheline;
    logic [IP_W-1:0]   ip;
    logic [IP_W-1:0]   pip;
  } sInstAlignIn;

  typedef struct packed {
    logic              predict_taken;
    logic [LINE_W-1:0] cacheline;
    logic [IP_W-1:0]   ip;
    logic [IP_W-1:0]   pip;
  } sIFetchQEntry;

  typedef enum logic [1:0] {
    IfqEmpty,
    IfqPartial,
    IfqFull
  } ifq_state_e;

  function automatic ifq_state_e ifq_state(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) begin
      return IfqEmpty;
    end else if (cnt >= depth) begin
      return IfqFull;
    end
    return IfqPartial;
  endfunction

  function automatic sInstAlignIn mk_align_in(input logic v, input sIFetchQEntry e);
    sInstAlignIn r;
    r.v             = v;
    r.predict_taken = e.predict_taken;
    r.cacheline     = e.cacheline;
    r.ip            = e.ip;
    r.pip           = e.pip;
    return r;
  endfunction

endpackage

// File: rtl/any1_ifq_ram.sv
// Fetch-queue storage: DEPTH entries, one synchronous write port and one
// asynchronous read port. Data is not reset.
module any1_ifq_ram
  import any1_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  sIFetchQEntry             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output sIFetchQEntry             rdata_o
);

  sIFetchQEntry mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/any1_ifetch_queue.sv
// Line-fetch queue between the I-cache and the instruction aligner. The oldest
// entry is held in a head register so the aligner sees a registered record.
module any1_ifetch_queue
  import any1_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   wr_i,
  output logic                   wr_rdy_o,
  input  logic [LINE_W-1:0]      line_i,
  input  logic [IP_W-1:0]        ip_i,
  input  logic [IP_W-1:0]        pip_i,
  input  logic                   pt_i,
  input  logic                   adv_i,
  output sInstAlignIn            o,
  output logic [$clog2(DEPTH):0] cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rd_addr;
  logic [CntW-1:0] cnt_q, cnt_d;
  sInstAlignIn     head_q, head_d;
  sIFetchQEntry    wr_entry, rd_entry;
  ifq_state_e      state;
  logic            push, pop;

  always_comb begin
    state    = ifq_state(int'(cnt_q), DEPTH);
    pop      = adv_i & head_q.v;
    // A full queue still accepts a push when the head leaves the same cycle.
    wr_rdy_o = ~flush_i & ((state != IfqFull) | pop);
    push     = wr_i & wr_rdy_o;
    wr_entry.predict_taken = pt_i;
    wr_entry.cacheline     = line_i;
    wr_entry.ip            = ip_i;
    wr_entry.pip           = pip_i;
    rd_addr  = rptr_q + PtrW'(1);
  end

  any1_ifq_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (push),
    .waddr_i(wptr_q),
    .wdata_i(wr_entry),
    .raddr_i(rd_addr),
    .rdata_o(rd_entry)
  );

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (flush_i) begin
      rptr_d   = '0;
      wptr_d   = '0;
      cnt_d    = '0;
      head_d.v = 1'b0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
      if (pop && (cnt_q > CntW'(1))) begin
        // Next-oldest entry is already in the array.
        head_d = mk_align_in(1'b1, rd_entry);
      end else if (push && ((cnt_q == '0) || pop)) begin
        // Queue is, or is becoming, empty: the incoming line bypasses to the head.
        head_d = mk_align_in(1'b1, wr_entry);
      end else if (pop) begin
        head_d.v = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign o     = head_q;
  assign cnt_o = cnt_q;

endmodule
